serial_negate_ctrl: RTL and testbench

- Word-level controller that sequences a bit-serial two's-complement cell over WIDTH-bit operands.
- Accepts a parallel word on a valid/ready input.
- Clears the cell's "first-one seen" state between words, then shifts the word LSB-first through the cell for WIDTH cycles.
- Collects the serial result and presents the negated word on a valid/ready output.
- Sits between a parallel producer and consumer, reusing the serial complementer as a shared datapath resource.

---
 rtl/serial_negate_pkg.sv | 13 +
 rtl/serial_comp_cell.sv | 28 ++
 rtl/serial_negate_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_negate_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_negate_pkg.sv
// Shared types and defaults for the bit-serial negation controller.
package serial_negate_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLR   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/serial_comp_cell.sv
// Bit-serial two's-complement cell: copies bits up to and including the
// first 1 seen (LSB first), inverts every bit after it.
module serial_comp_cell (
   input  logic clk,
   input  logic r_n,
   input  logic clr,
   input  logic en,
   input  logic i,
   output logic y
);

   logic seen;

   // "first one seen" flag; clr restarts it for a new word
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         seen <= 1'b0;
      end else if (clr) begin
         seen <= 1'b0;
      end else if (en) begin
         seen <= seen | i;
      end
   end

   // Serial output bit
   assign y = i ^ seen;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Word-level controller: accepts a parallel operand, streams it LSB-first
// through the shared serial complement cell and returns the negated word.
module serial_negate_ctrl
   import serial_negate_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             r_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] result_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_next_q;
   logic             cell_clr;
   logic             cell_en;
   logic             cell_i;
   logic             cell_y;
   logic             last_shift;

   assign last_shift = (cnt_q == LAST_CNT);

   serial_comp_cell u_cell (
      .clk (clk),
      .r_n (r_n),
      .clr (cell_clr),
      .en  (cell_en),
      .i   (cell_i),
      .y   (cell_y)
   );

   // State register
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and cell control decode
   always_comb begin
      state_d  = state_q;
      cell_clr = 1'b0;
      cell_en  = 1'b0;
      cell_i   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CLR;
            end
         end
         CLR: begin
            cell_clr = 1'b1;
            state_d  = SHIFT;
         end
         SHIFT: begin
            cell_en = 1'b1;
            cell_i  = shift_q[0];
            if (last_shift) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture, serial shifting and result collection
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         shift_q    <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         ovf_next_q <= 1'b0;
         out_data   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  shift_q    <= in_data;
                  ovf_next_q <= (in_data == MOST_NEG);
                  cnt_q      <= '0;
               end
            end
            SHIFT: begin
               result_q <= {cell_y, result_q[WIDTH-1:1]};
               shift_q  <= shift_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_shift) begin
                  out_data <= {cell_y, result_q[WIDTH-1:1]};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered Moore outputs, decoded from the upcoming state
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == DONE);
         busy      <= (state_d == CLR) || (state_d == SHIFT);
         if ((state_q == SHIFT) && last_shift) begin
            ovf <= ovf_next_q;
         end else if (state_d != DONE) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Self-checking bench for serial_negate_ctrl at WIDTH=8 and WIDTH=5.
module tb_serial_negate_ctrl;

   logic       clk;
   logic       r_n;
   int         cyc;
   int         checks;
   int         errors;

   logic       in_valid, in_ready, out_valid, out_ready, ovf, busy;
   logic [7:0] in_data, out_data;

   logic       in_valid5, in_ready5, out_valid5, out_ready5, ovf5, busy5;
   logic [4:0] in_data5, out_data5;

   serial_negate_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .r_n(r_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ovf(ovf), .busy(busy)
   );

   serial_negate_ctrl #(.WIDTH(5)) dut5 (
      .clk(clk), .r_n(r_n),
      .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
      .ovf(ovf5), .busy(busy5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Transaction-level model: expected words in order, plus the acceptance edge
   // of the word in flight; valid must appear WIDTH+1 edges after acceptance.
   logic [8:0] q8[$];
   logic [5:0] q5[$];
   int         acc8, acc5, nacc8, nacc5, npop8, npop5;
   logic [7:0] neg8;
   logic [4:0] neg5;

   always @(negedge clk) begin
      if (!r_n) begin
         chk("rst8_in_ready", in_ready, 1);
         chk("rst8_out_valid", out_valid, 0);
         chk("rst8_busy", busy, 0);
         chk("rst8_ovf", ovf, 0);
         q8.delete();
      end else begin
         if (q8.size() == 0) begin
            chk("idle8_in_ready", in_ready, 1);
            chk("idle8_busy", busy, 0);
            chk("idle8_out_valid", out_valid, 0);
            chk("idle8_ovf", ovf, 0);
         end else if (cyc < acc8 + 9) begin
            chk("work8_in_ready", in_ready, 0);
            chk("work8_busy", busy, 1);
            chk("work8_out_valid", out_valid, 0);
            chk("work8_ovf", ovf, 0);
         end else begin
            chk("done8_out_valid", out_valid, 1);
            chk("done8_busy", busy, 0);
            chk("done8_in_ready", in_ready, 0);
            chk("done8_out_data", out_data, q8[0][7:0]);
            chk("done8_ovf", ovf, q8[0][8]);
            if (out_ready) begin
               void'(q8.pop_front());
               npop8++;
            end
         end
         if (q8.size() == 0 && in_valid && !(out_valid && out_ready)) begin
            neg8 = -in_data;
            q8.push_back({in_data == 8'h80, neg8});
            acc8 = cyc + 1;
            nacc8++;
         end
      end
   end

   always @(negedge clk) begin
      if (!r_n) begin
         chk("rst5_in_ready", in_ready5, 1);
         chk("rst5_out_valid", out_valid5, 0);
         chk("rst5_busy", busy5, 0);
         chk("rst5_ovf", ovf5, 0);
         q5.delete();
      end else begin
         if (q5.size() == 0) begin
            chk("idle5_in_ready", in_ready5, 1);
            chk("idle5_busy", busy5, 0);
            chk("idle5_out_valid", out_valid5, 0);
            chk("idle5_ovf", ovf5, 0);
         end else if (cyc < acc5 + 6) begin
            chk("work5_in_ready", in_ready5, 0);
            chk("work5_busy", busy5, 1);
            chk("work5_out_valid", out_valid5, 0);
            chk("work5_ovf", ovf5, 0);
         end else begin
            chk("done5_out_valid", out_valid5, 1);
            chk("done5_busy", busy5, 0);
            chk("done5_in_ready", in_ready5, 0);
            chk("done5_out_data", out_data5, q5[0][4:0]);
            chk("done5_ovf", ovf5, q5[0][5]);
            if (out_ready5) begin
               void'(q5.pop_front());
               npop5++;
            end
         end
         if (q5.size() == 0 && in_valid5 && !(out_valid5 && out_ready5)) begin
            neg5 = -in_data5;
            q5.push_back({in_data5 == 5'h10, neg5});
            acc5 = cyc + 1;
            nacc5++;
         end
      end
   end

   // One directed word on dut8; stall>0 holds out_ready low after out_valid
   task automatic run_word(input logic [7:0] d, input logic [7:0] exp, input logic exp_ovf,
                           input int stall, input string tag);
      int n, nb, acc;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = (stall == 0);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept"}, in_ready, 1);
      acc = cyc + 1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      nb = 0;
      n  = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         if (busy) nb++;
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, cyc - acc, 9);
      chk({tag, "_busy_cycles"}, nb, 9);
      chk({tag, "_data"}, out_data, exp);
      chk({tag, "_ovf"}, ovf, exp_ovf);
      if (stall > 0) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = 8'h11;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_data"}, out_data, exp);
            chk({tag, "_stall_in_ready"}, in_ready, 0);
         end
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid  = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      chk({tag, "_after_valid"}, out_valid, 0);
      chk({tag, "_after_in_ready"}, in_ready, 1);
      chk({tag, "_after_hold"}, out_data, exp);
   endtask

   task automatic rand8(input int nw);
      int         sent, guard;
      logic       took;
      logic [7:0] corner[5];
      corner = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h01};
      sent = 0; guard = 0; took = 1'b0;
      while (sent < nw && guard < 20000) begin
         @(posedge clk); #1;
         guard++;
         if (took) begin
            in_valid = 1'b0;
            took     = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data  = (sent < 5) ? corner[sent] : 8'($urandom);
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            took = 1'b1;
            sent++;
         end
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic rand5(input int nw);
      int         sent, guard;
      logic       took;
      logic [4:0] corner[5];
      corner = '{5'h00, 5'h10, 5'h0F, 5'h1F, 5'h01};
      sent = 0; guard = 0; took = 1'b0;
      while (sent < nw && guard < 20000) begin
         @(posedge clk); #1;
         guard++;
         if (took) begin
            in_valid5 = 1'b0;
            took      = 1'b0;
         end
         out_ready5 = 1'($urandom_range(0, 1));
         if (!in_valid5 && $urandom_range(0, 3) != 0) begin
            in_valid5 = 1'b1;
            in_data5  = (sent < 5) ? corner[sent] : 5'($urandom);
         end
         @(negedge clk);
         if (in_valid5 && in_ready5) begin
            took = 1'b1;
            sent++;
         end
      end
      @(posedge clk); #1;
      in_valid5  = 1'b0;
      out_ready5 = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         na, nr, base_p8, base_a8, base_p5, base_a5, n;
      logic [7:0] res[2];
      int         ac[2], hs[2];

      cyc = 0; checks = 0; errors = 0;
      acc8 = 0; acc5 = 0; nacc8 = 0; nacc5 = 0; npop8 = 0; npop5 = 0;
      r_n = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      in_valid5 = 1'b0; in_data5 = 5'h00; out_ready5 = 1'b0;
      #2 r_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out_data", out_data, 8'h00);
      chk("reset_in_ready", in_ready, 1);
      #2 r_n = 1'b1;

      run_word(8'h01, 8'hFF, 1'b0, 0, "w01");
      run_word(8'h00, 8'h00, 1'b0, 0, "w00");
      run_word(8'h80, 8'h80, 1'b1, 0, "w80");
      run_word(8'h28, 8'hD8, 1'b0, 5, "w28_stall");

      // Back-to-back words with in_valid held high
      na = 0; nr = 0;
      res[0] = 8'h00; res[1] = 8'h00; ac[0] = 0; ac[1] = 0; hs[0] = 0; hs[1] = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b1;
      for (int k = 0; k < 60 && nr < 2; k++) begin
         @(negedge clk);
         if (in_valid && in_ready && na < 2) begin
            ac[na] = cyc;
            na++;
         end
         if (out_valid && out_ready && nr < 2) begin
            res[nr] = out_data;
            hs[nr]  = cyc;
            nr++;
         end
         @(posedge clk); #1;
         if (na == 1) in_data = 8'hFB;
         if (na == 2) in_valid = 1'b0;
      end
      chk("b2b_count", nr, 2);
      chk("b2b_res0", res[0], 8'hFB);
      chk("b2b_res1", res[1], 8'h05);
      chk("b2b_accept_after_handshake", ac[1], hs[0] + 1);
      chk("b2b_throughput", ac[1] - ac[0], 11);

      // Reset in the middle of SHIFT
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h6C; out_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #3;
      chk("rst_mid_busy_before", busy, 1);
      r_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ovf", ovf, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_data", out_data, 8'h00);
      @(negedge clk);
      #2 r_n = 1'b1;
      run_word(8'h03, 8'hFD, 1'b0, 0, "w03_post_reset");

      // Random traffic on both widths concurrently
      base_p8 = npop8; base_a8 = nacc8; base_p5 = npop5; base_a5 = nacc5;
      fork
         rand8(200);
         rand5(200);
      join
      n = 0;
      while ((q8.size() != 0 || q5.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("rand8_accepted", nacc8 - base_a8, 200);
      chk("rand8_returned", npop8 - base_p8, 200);
      chk("rand5_accepted", nacc5 - base_a5, 200);
      chk("rand5_returned", npop5 - base_p5, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
